// File: rtl/picorv32_mem_arbiter_if.sv
// PicoRV32 native memory handshake bundle. The master drives the request and payload.
// The slave returns the completion pulse and the read data.
interface picorv32_mem_arbiter_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv32_mem_arbiter.sv
// Round-robin arbiter that shares one PicoRV32 native memory port between two requesters.
// The grant is locked for a whole transaction, and a watchdog ends transactions that are never answered.
module picorv32_mem_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    picorv32_mem_arbiter_if.slave  m0,
    picorv32_mem_arbiter_if.slave  m1,
    picorv32_mem_arbiter_if.master mem,
    output logic                   owner,
    output logic                   busy,
    output logic                   timeout_err
);
    localparam int unsigned     CntW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic            owner_q, owner_d;
    logic            mem_valid_q, mem_valid_d;
    logic            mem_instr_q, mem_instr_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_wstrb_q, mem_wstrb_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        grant, grant_idx;
    logic        wd_fire, done;
    logic        m0_ready, m1_ready;
    logic [31:0] rsp_rdata;

    // On a tie, the requester that was not served last wins.
    assign grant     = m0.mem_valid | m1.mem_valid;
    assign grant_idx = m1.mem_valid & (~m0.mem_valid | ~last_q);

    // mem_ready takes priority over the watchdog in the same cycle.
    assign wd_fire = (TIMEOUT != 0) && (state_q == StBusy) && !mem.mem_ready &&
                     (cnt_q == CntLast);
    assign done    = (state_q == StBusy) && (mem.mem_ready || wd_fire);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        mem_valid_d = mem_valid_q;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d     = StBusy;
                    owner_d     = grant_idx;
                    mem_valid_d = 1'b1;
                    mem_instr_d = grant_idx ? m1.mem_instr : m0.mem_instr;
                    mem_addr_d  = grant_idx ? m1.mem_addr  : m0.mem_addr;
                    mem_wdata_d = grant_idx ? m1.mem_wdata : m0.mem_wdata;
                    mem_wstrb_d = grant_idx ? m1.mem_wstrb : m0.mem_wstrb;
                    cnt_d       = '0;
                end
            end
            StBusy: begin
                if (done) begin
                    state_d     = StIdle;
                    mem_valid_d = 1'b0;
                    last_d      = owner_q;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            mem_valid_q <= mem_valid_d;
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_rdata = mem.mem_ready ? mem.mem_rdata : 32'hFFFF_FFFF;
    assign m0_ready  = done & ~owner_q;
    assign m1_ready  = done & owner_q;

    assign m0.mem_ready = m0_ready;
    assign m1.mem_ready = m1_ready;
    assign m0.mem_rdata = m0_ready ? rsp_rdata : 32'h0;
    assign m1.mem_rdata = m1_ready ? rsp_rdata : 32'h0;

    assign mem.mem_valid = mem_valid_q;
    assign mem.mem_instr = mem_instr_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wstrb = mem_wstrb_q;

    assign owner       = owner_q;
    assign busy        = (state_q == StBusy);
    assign timeout_err = wd_fire;
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Scoreboard bench for picorv32_mem_arbiter: expected downstream requests and per-requester
// responses are queued when stimulus is issued and compared when the DUT produces them.
module tb_picorv32_mem_arbiter;
    localparam int unsigned TIMEOUT = 8;

    typedef struct packed {
        logic        owner;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        tmo;
        logic [31:0] cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic owner, busy, timeout_err;

    picorv32_mem_arbiter_if m0_if ();
    picorv32_mem_arbiter_if m1_if ();
    picorv32_mem_arbiter_if mem_if ();

    picorv32_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .m0          (m0_if),
        .m1          (m1_if),
        .mem         (mem_if),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    req_t req_q[$];
    rsp_t rsp_q0[$];
    rsp_t rsp_q1[$];

    // Downstream responder controls; resp_delay 0 means never answer.
    int          resp_delay = 0;
    logic [31:0] resp_fixed = 32'h0;
    bit          rdata_from_addr = 1'b0;
    bit          poke = 1'b0;
    logic [31:0] bcnt = 32'h0;

    bit chk_drop = 1'b0;
    bit gap_check = 1'b0;
    bit gap_armed = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0000;
    endfunction

    task automatic push_req(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input bit instr);
        req_t r;
        r.owner = port;
        r.instr = instr;
        r.addr  = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        req_q.push_back(r);
    endtask

    task automatic push_rsp(input bit port, input logic [31:0] rdata, input bit tmo,
                            input logic [31:0] c);
        rsp_t s;
        s.rdata = rdata;
        s.tmo   = tmo;
        s.cyc   = c;
        if (port) rsp_q1.push_back(s);
        else      rsp_q0.push_back(s);
    endtask

    // Native requester: hold the request until ready is seen, then drop valid on the next edge.
    task automatic do_req(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input bit instr);
        bit seen = 1'b0;
        if (port) begin
            m1_if.mem_valid = 1'b1; m1_if.mem_instr = instr; m1_if.mem_addr = addr;
            m1_if.mem_wdata = wdata; m1_if.mem_wstrb = wstrb;
        end else begin
            m0_if.mem_valid = 1'b1; m0_if.mem_instr = instr; m0_if.mem_addr = addr;
            m0_if.mem_wdata = wdata; m0_if.mem_wstrb = wstrb;
        end
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            seen = port ? m1_if.mem_ready : m0_if.mem_ready;
        end
        check("req_done", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        if (port) m1_if.mem_valid = 1'b0;
        else      m0_if.mem_valid = 1'b0;
    endtask

    // Downstream memory model.
    initial begin
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_if.mem_ready = 1'b0;
            mem_if.mem_rdata = 32'h0;
            if (mem_if.mem_valid) begin
                bcnt++;
                if (resp_delay != 0 && bcnt == 32'(resp_delay)) begin
                    mem_if.mem_ready = 1'b1;
                    mem_if.mem_rdata = rdata_from_addr ? rdata_of(mem_if.mem_addr) : resp_fixed;
                end
            end else begin
                bcnt = 32'h0;
                if (poke) begin
                    mem_if.mem_ready = 1'b1;
                    mem_if.mem_rdata = 32'hDEAD_BEEF;
                end
            end
        end
    end

    // Downstream request monitor.
    initial begin
        bit   prev_v = 1'b0;
        int   gap = 0;
        req_t r;
        @(negedge reset);
        forever begin
            @(negedge clk);
            if (mem_if.mem_valid && !prev_v) begin
                if (gap_armed) check("idle_gap", 32'(gap), 32'd1);
                if (gap_check) gap_armed = 1'b1;
                rise_cyc = cyc;
                if (req_q.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                end else begin
                    r = req_q.pop_front();
                    check("req_owner", 32'(owner), 32'(r.owner));
                    check("req_addr", mem_if.mem_addr, r.addr);
                    check("req_wdata", mem_if.mem_wdata, r.wdata);
                    check("req_wstrb", 32'(mem_if.mem_wstrb), 32'(r.wstrb));
                    check("req_instr", 32'(mem_if.mem_instr), 32'(r.instr));
                end
            end
            if (!mem_if.mem_valid) gap++;
            else                   gap = 0;
            prev_v = mem_if.mem_valid;
        end
    end

    // Requester response monitor.
    initial begin
        rsp_t        s;
        logic [31:0] quiet;
        @(negedge reset);
        forever begin
            @(negedge clk);
            if (chk_drop) begin
                check("drop_valid", 32'(mem_if.mem_valid), 32'd0);
                check("drop_busy", 32'(busy), 32'd0);
                chk_drop = 1'b0;
            end
            quiet = (m0_if.mem_ready ? 32'h0 : m0_if.mem_rdata) |
                    (m1_if.mem_ready ? 32'h0 : m1_if.mem_rdata) |
                    {31'h0, timeout_err & ~m0_if.mem_ready & ~m1_if.mem_ready} |
                    {30'h0, m0_if.mem_ready & m1_if.mem_ready, 1'b0};
            check("quiet_outputs", quiet, 32'h0);
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? m0_if.mem_ready : m1_if.mem_ready) begin
                    if (((p == 0) ? rsp_q0.size() : rsp_q1.size()) == 0) begin
                        check("unexpected_rsp", 32'(p + 1), 32'd0);
                    end else begin
                        s = (p == 0) ? rsp_q0.pop_front() : rsp_q1.pop_front();
                        check("rsp_owner", 32'(owner), 32'(p));
                        check("rsp_rdata", (p == 0) ? m0_if.mem_rdata : m1_if.mem_rdata, s.rdata);
                        check("rsp_timeout_err", 32'(timeout_err), 32'(s.tmo));
                        check("rsp_busy_cycle", bcnt, s.cyc);
                        chk_drop = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int  t_req;
        bit  seen;
        m0_if.mem_valid = 1'b0; m0_if.mem_instr = 1'b0; m0_if.mem_addr = 32'h0;
        m0_if.mem_wdata = 32'h0; m0_if.mem_wstrb = 4'h0;
        m1_if.mem_valid = 1'b0; m1_if.mem_instr = 1'b0; m1_if.mem_addr = 32'h0;
        m1_if.mem_wdata = 32'h0; m1_if.mem_wstrb = 4'h0;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_valid", 32'(mem_if.mem_valid), 32'd0);
        check("rst_mem_instr", 32'(mem_if.mem_instr), 32'd0);
        check("rst_mem_addr", mem_if.mem_addr, 32'h0);
        check("rst_mem_wdata", mem_if.mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(mem_if.mem_wstrb), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_ready", {30'h0, m1_if.mem_ready, m0_if.mem_ready}, 32'h0);
        check("rst_rdata", m0_if.mem_rdata | m1_if.mem_rdata, 32'h0);

        // Tie at the first edge after reset: m0 wins, then m1.
        resp_delay = 2;
        rdata_from_addr = 1'b1;
        push_req(1'b0, 32'h10, 32'h11, 4'hF, 1'b0);
        push_rsp(1'b0, rdata_of(32'h10), 1'b0, 32'd2);
        push_req(1'b1, 32'h20, 32'h22, 4'h3, 1'b0);
        push_rsp(1'b1, rdata_of(32'h20), 1'b0, 32'd2);
        reset = 1'b0;
        fork
            do_req(1'b0, 32'h10, 32'h11, 4'hF, 1'b0);
            do_req(1'b1, 32'h20, 32'h22, 4'h3, 1'b0);
        join

        // Fairness: both continuously requesting, grants alternate 0,1,0,1,0,1.
        repeat (2) @(posedge clk);
        #1;
        resp_delay = 1;
        gap_check = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_req(1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'h0, 1'b1);
            push_rsp(1'b0, rdata_of(32'h1000 + 32'(i * 4)), 1'b0, 32'd1);
            push_req(1'b1, 32'h2000 + 32'(i * 4), 32'h0, 4'h0, 1'b0);
            push_rsp(1'b1, rdata_of(32'h2000 + 32'(i * 4)), 1'b0, 32'd1);
        end
        fork
            for (int i = 0; i < 3; i++) do_req(1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'h0, 1'b1);
            for (int j = 0; j < 3; j++) do_req(1'b1, 32'h2000 + 32'(j * 4), 32'h0, 4'h0, 1'b0);
        join
        gap_check = 1'b0;
        gap_armed = 1'b0;

        // Spurious mem_ready in IDLE must be ignored, then a single read from m0.
        repeat (2) @(posedge clk);
        @(negedge clk);
        poke = 1'b1;
        @(posedge clk);
        #3;
        poke = 1'b0;
        @(posedge clk);
        #1;
        resp_delay = 3;
        rdata_from_addr = 1'b0;
        resp_fixed = 32'hCAFE_F00D;
        push_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
        push_rsp(1'b0, 32'hCAFE_F00D, 1'b0, 32'd3);
        t_req = cyc;
        do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
        check("grant_latency", 32'(rise_cyc - t_req), 32'd1);

        // Watchdog: nothing answers; m0 times out, then the waiting m1 is served and times out.
        repeat (2) @(posedge clk);
        #1;
        resp_delay = 0;
        push_req(1'b0, 32'h300, 32'h0, 4'h0, 1'b0);
        push_rsp(1'b0, 32'hFFFF_FFFF, 1'b1, 32'd8);
        push_req(1'b1, 32'h400, 32'h44, 4'h1, 1'b0);
        push_rsp(1'b1, 32'hFFFF_FFFF, 1'b1, 32'd8);
        fork
            do_req(1'b0, 32'h300, 32'h0, 4'h0, 1'b0);
            begin
                @(posedge clk);
                #1;
                do_req(1'b1, 32'h400, 32'h44, 4'h1, 1'b0);
            end
        join

        // mem_ready in the watchdog cycle wins.
        repeat (2) @(posedge clk);
        #1;
        resp_delay = 8;
        resp_fixed = 32'h1234_5678;
        push_req(1'b0, 32'h500, 32'h0, 4'h0, 1'b0);
        push_rsp(1'b0, 32'h1234_5678, 1'b0, 32'd8);
        do_req(1'b0, 32'h500, 32'h0, 4'h0, 1'b0);

        // Asynchronous reset while m1 is being served.
        repeat (2) @(posedge clk);
        #1;
        resp_delay = 0;
        push_req(1'b1, 32'h600, 32'h66, 4'hF, 1'b0);
        m1_if.mem_valid = 1'b1; m1_if.mem_instr = 1'b0; m1_if.mem_addr = 32'h600;
        m1_if.mem_wdata = 32'h66; m1_if.mem_wstrb = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = busy && owner;
        end
        check("rst_test_busy_m1", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_mem_valid", 32'(mem_if.mem_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_owner", 32'(owner), 32'd0);
        check("async_rst_ready", {30'h0, m1_if.mem_ready, m0_if.mem_ready}, 32'h0);
        m1_if.mem_valid = 1'b0;
        resp_delay = 2;
        resp_fixed = 32'h0BAD_CAFE;
        push_req(1'b0, 32'h700, 32'h0, 4'h0, 1'b0);
        push_rsp(1'b0, 32'h0BAD_CAFE, 1'b0, 32'd2);
        fork
            do_req(1'b0, 32'h700, 32'h0, 4'h0, 1'b0);
            begin
                @(negedge clk);
                check("rst_hold_valid", 32'(mem_if.mem_valid), 32'd0);
                reset = 1'b0;
            end
        join

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("rsp_q0_drained", 32'(rsp_q0.size()), 32'd0);
        check("rsp_q1_drained", 32'(rsp_q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/picorv32_mem_arbiter.md
# picorv32_mem_arbiter

Two-requester arbiter for the native PicoRV32 memory interface. It shares one downstream native port, normally the input of the AXI4-lite adapter, between requester 0 (the core) and requester 1 (for example a DMA or debug master). Arbitration is round-robin and the grant is locked for a whole transaction. A watchdog counter terminates any transaction the downstream never acknowledges.

## Interface
Parameters:
- TIMEOUT, default 1024: cycles in BUSY before a forced completion. 0 disables the watchdog.

Ports (clock and reset first):
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_mem_valid / m1_mem_valid  in  1  requester request
- m0_mem_instr / m1_mem_instr  in  1  instruction-fetch qualifier
- m0_mem_addr / m1_mem_addr  in  32  byte address
- m0_mem_wdata / m1_mem_wdata  in  32  write data
- m0_mem_wstrb / m1_mem_wstrb  in  4  byte strobes; 0 means read
- m0_mem_ready / m1_mem_ready  out  1  completion pulse to requester
- m0_mem_rdata / m1_mem_rdata  out  32  read data, valid while the matching ready is 1
- mem_valid  out  1  downstream request, registered
- mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]  out  downstream payload, registered
- mem_ready  in  1  downstream completion
- mem_rdata  in  32  downstream read data
- owner  out  1  index of the current or last granted requester
- busy  out  1  high in BUSY state
- timeout_err  out  1  one-cycle pulse on watchdog completion

## Operation
- Protocol: a requester holds valid and payload stable until it sees ready=1 for one cycle. It then drops valid on the following edge (native PicoRV32 behaviour).
- State machine has two states, IDLE and BUSY.
- IDLE:
  - If no valid is present, stay in IDLE.
  - If exactly one valid is present, grant that requester.
  - If both are present, grant the requester that is not `last` (round-robin).
  - On grant:
    - register the granted payload onto the downstream outputs
    - set mem_valid=1 and owner to the granted index
    - clear the timeout counter
    - go to BUSY.
- BUSY:
  - mem_valid and the payload are held constant.
  - Completion on mem_ready=1:
    - assert m<owner>_mem_ready=1 combinationally in the same cycle; the other requester's ready stays 0
    - pass m<owner>_mem_rdata = mem_rdata through
    - on the next edge set mem_valid=0, last=owner, and go to IDLE.
  - Watchdog, when TIMEOUT≠0:
    - the counter increments each BUSY cycle without mem_ready
    - in the cycle where counter==TIMEOUT-1 and mem_ready=0, assert m<owner>_mem_ready=1 with rdata=32'hFFFF_FFFF and pulse timeout_err=1
    - then go to IDLE with mem_valid=0.
- If mem_ready=1 and the watchdog fires in the same cycle, mem_ready wins: normal completion, no timeout_err.
- mem_ready seen in IDLE is ignored.
- Requester rdata outputs read 0 whenever their ready is 0.
- If the owner drops valid during BUSY (a protocol violation), the transaction still completes normally.
- Counter width is $clog2(TIMEOUT+1), minimum 1.

## Timing
- Reset values:
  - state IDLE, last=1, so requester 0 wins the first tie
  - mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0
  - owner=0, busy=0, timeout_err=0, both ready=0, both rdata=0, counter=0.
- Reset asserted mid-transaction:
  - all of the above apply immediately (asynchronous), and the pending transaction is abandoned
  - no ready is generated.
- Grant latency: a valid sampled in IDLE at edge N drives mem_valid=1 from edge N.
- Downstream-to-requester completion: 0 cycles, combinational ready and rdata path.
- Minimum spacing is one IDLE cycle between consecutive downstream transactions. Back-to-back throughput is at most one transaction per 2 cycles when mem_ready returns immediately.
- Fairness: with both requesters continuously valid, grants strictly alternate.

## Test plan
- Single read from m0, addr 0x0000_0100, wstrb 0; downstream returns ready with rdata 0xCAFE_F00D after 3 cycles -> mem_valid rises 1 cycle after m0_mem_valid; m0_mem_ready pulses once with rdata 0xCAFE_F00D; m1_mem_ready stays 0.
- m0 and m1 both valid at the first edge after reset, each a write (m0 addr 0x10 wdata 0x11 wstrb 0xF; m1 addr 0x20 wdata 0x22 wstrb 0x3) -> first downstream request is m0's payload, second is m1's; owner goes 0 then 1.
- Both requesters continuously re-requesting for 6 transactions -> downstream owner sequence 0,1,0,1,0,1; mem_valid low exactly one cycle between transactions.
- TIMEOUT=8, downstream never asserts ready -> in the 8th BUSY cycle owner ready=1, rdata=0xFFFF_FFFF, timeout_err=1 for one cycle; mem_valid=0 next cycle; the other requester is granted afterwards.
- TIMEOUT=8 with mem_ready arriving exactly in the 8th BUSY cycle with rdata 0x1234_5678 -> normal completion with 0x1234_5678, timeout_err stays 0.
- Reset pulsed while BUSY on m1 -> mem_valid, busy and owner go 0 immediately and no ready is generated; after release, a pending m0 request is granted normally.
